// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece kinds, 4x4 shape masks (row-major, index 0 = top-left),
// FSM state encoding and board dimensions.
package tetris_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 24;
  localparam logic [2:0] KIND_I = 3'd0;
  localparam logic [2:0] KIND_O = 3'd1;
  localparam logic [2:0] KIND_T = 3'd2;
  localparam logic [2:0] KIND_S = 3'd3;
  localparam logic [2:0] KIND_Z = 3'd4;
  localparam logic [2:0] KIND_J = 3'd5;
  localparam logic [2:0] KIND_L = 3'd6;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_FALL  = 3'd2;
  localparam logic [2:0] ST_LOCK  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;
  // each hex digit is one bitmap row, leftmost bit is column 0
  localparam logic [0:6][0:3][0:15] SHAPE = '{
    '{16'h0F00, 16'h2222, 16'h00F0, 16'h4444},
    '{16'h6600, 16'h6600, 16'h6600, 16'h6600},
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80},
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440}
  };
endpackage

// File: rtl/piece_lfsr.sv
// piece_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) mapped to a piece kind.
module piece_lfsr
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] kind_new
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
  assign kind_new = (lfsr_q[2:0] == 3'd7) ? KIND_I : lfsr_q[2:0];
endmodule

// File: rtl/piece_fall_ctrl.sv
// piece_fall_ctrl: owns the falling piece (spawn, gravity, moves, hard drop, lock handoff).
// Define NEXT_PIECE_EN to add a registered next_kind preview output.
module piece_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int         GRAVITY_CYCLES = 25_000_000,
  parameter int         DROP_CYCLES    = 1,
  parameter logic [3:0] SPAWN_X        = 4'd3,
  parameter logic [4:0] SPAWN_Y        = 5'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmd_left,
  input  logic        cmd_right,
  input  logic        cmd_rot,
  input  logic        cmd_drop,
  input  logic        hit,
  input  logic        game_over,
  input  logic        lock_ack,
  output logic [3:0]  cand_x,
  output logic [4:0]  cand_y,
  output logic [0:15] cand_float,
  output logic [3:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic [0:15] float,
  output logic [2:0]  kind,
`ifdef NEXT_PIECE_EN
  output logic [2:0]  next_kind,
`endif
  output logic        piece_valid,
  output logic        lock_req,
  output logic        over
);
  localparam logic [31:0] GRAV_MAX = 32'(GRAVITY_CYCLES - 1);
  localparam logic [31:0] DROP_MAX = 32'(DROP_CYCLES - 1);
  logic [2:0]  state_q, state_d, kind_q, kind_d, lfsr_kind, spawn_kind;
  logic [3:0]  pos_x_q, pos_x_d;
  logic [4:0]  pos_y_q, pos_y_d;
  logic [0:15] float_q, float_d;
  logic [1:0]  rot_q, rot_d, cand_rot;
  logic [31:0] cnt_q, cnt_d;
  logic        drop_q, drop_d, go_q, go_d, due, latch;
  piece_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .kind_new(lfsr_kind));
`ifdef NEXT_PIECE_EN
  logic [2:0] next_kind_q, next_kind_d;
  always_comb next_kind_d = (state_q == ST_SPAWN || (start && (state_q == ST_IDLE || state_q == ST_OVER)))
                            ? lfsr_kind : next_kind_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) next_kind_q <= 3'd0;
    else next_kind_q <= next_kind_d;
  assign spawn_kind = next_kind_q;
  assign next_kind  = next_kind_q;
`else
  assign spawn_kind = lfsr_kind;
`endif
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    float_d    = float_q;
    kind_d     = kind_q;
    rot_d      = rot_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    go_d       = go_q;
    cand_x     = pos_x_q;
    cand_y     = pos_y_q;
    cand_float = float_q;
    cand_rot   = rot_q;
    // the same counter paces gravity normally and row steps during a hard drop
    due        = cnt_q == (drop_q ? DROP_MAX : GRAV_MAX);
    latch      = !drop_q && cmd_drop;
    case (state_q)
      ST_IDLE: state_d = start ? ST_SPAWN : ST_IDLE;
      ST_SPAWN: begin
        cand_x     = SPAWN_X;
        cand_y     = SPAWN_Y;
        cand_float = SHAPE[spawn_kind][0];
        cand_rot   = 2'd0;
        state_d    = hit ? ST_OVER : ST_FALL;
        if (!hit) begin
          pos_x_d = cand_x;
          pos_y_d = cand_y;
          float_d = cand_float;
          rot_d   = cand_rot;
          kind_d  = spawn_kind;
          cnt_d   = '0;
          drop_d  = 1'b0;
        end
      end
      ST_FALL: begin
        if (due) cand_y = pos_y_q - 5'd1;
        else if (!drop_q && cmd_rot) begin
          cand_rot   = rot_q + 2'd1;
          cand_float = SHAPE[kind_q][cand_rot];
        end
        else if (!drop_q && cmd_left) cand_x = pos_x_q - 4'd1;
        else if (!drop_q && cmd_right) cand_x = pos_x_q + 4'd1;
        cnt_d  = (due || latch) ? '0 : cnt_q + 32'd1;
        drop_d = drop_q || cmd_drop;
        if (!hit) begin
          pos_x_d = cand_x;
          pos_y_d = cand_y;
          float_d = cand_float;
          rot_d   = cand_rot;
        end else if (due) begin
          state_d = ST_LOCK;
          go_d    = game_over;
        end
      end
      ST_LOCK: state_d = lock_ack ? (go_q ? ST_OVER : ST_SPAWN) : ST_LOCK;
      ST_OVER: state_d = start ? ST_SPAWN : ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      float_q <= '0;
      kind_q  <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      float_q <= float_d;
      kind_q  <= kind_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      go_q    <= go_d;
    end
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign float       = float_q;
  assign kind        = kind_q;
  assign piece_valid = state_q == ST_FALL || state_q == ST_LOCK;
  assign lock_req    = state_q == ST_LOCK;
  assign over        = state_q == ST_OVER;
endmodule

// File: doc/piece_fall_ctrl.md
Name: piece_fall_ctrl

Overview:
- Owns the active falling tetromino: spawns it, applies gravity and player moves/rotations, detects landing, and hands the piece to the board for merging.
- Drives the anchor position and 4x4 float bitmap consumed by the game-over checker and the collision checker.
- Samples the checker's game_over at lock time.
- Sits between input debouncing/edge detection (upstream) and the board/game-over logic (downstream).

Parameters:
- GRAVITY_CYCLES, 25_000_000: clk cycles per one-row gravity step.
- DROP_CYCLES, 1: clk cycles between rows during a hard drop.
- SPAWN_X, 3: pos_x loaded at spawn.
- SPAWN_Y, 20: pos_y loaded at spawn.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- cmd_left, cmd_right, cmd_rot, cmd_drop  in  1 each  one-cycle pulses from input edge detectors
- hit  in  1  combinational collision result for cand_x/cand_y/cand_float (external checker, same cycle)
- game_over  in  1  game-over checker output for current pos_y/float
- lock_ack  in  1  board has merged the piece and finished line clearing
- cand_x  out  4  trial anchor x
- cand_y  out  5  trial anchor y
- cand_float  out  16  trial bitmap [0:15], row-major, index 0 = top-left
- pos_x  out  4  committed anchor x
- pos_y  out  5  committed anchor y (0 = bottom row; gravity decrements)
- float  out  16  committed bitmap [0:15]
- kind  out  3  piece type 0..6 (I,O,T,S,Z,J,L)
- piece_valid  out  1  a piece is active (FALL/LOCK)
- lock_req  out  1  request board merge of pos_x/pos_y/float
- over  out  1  game ended

Behaviour:
- Reset: state=IDLE. pos_x=0, pos_y=0, float=0, kind=0, rot=0. piece_valid=0, lock_req=0, over=0. Gravity counter=0. LFSR=16'hACE1. cand_* = committed values.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in every state, including reset release. Next kind = lfsr[2:0]; value 7 maps to 0.
- State IDLE: start -> SPAWN.
- State SPAWN (1 cycle):
  - cand = (SPAWN_X, SPAWN_Y, shape[kind_new][0]).
  - If hit -> OVER; nothing is committed.
  - Else commit, rot=0, clear gravity counter -> FALL.
- State FALL, one trial per cycle, priority:
  1. Hard drop active: trial y-1 every DROP_CYCLES.
  2. Gravity counter reached GRAVITY_CYCLES-1: trial y-1, counter clears.
  3. cmd_rot: trial shape[kind][rot+1 mod 4].
  4. cmd_left: trial x-1.
  5. cmd_right: trial x+1.
- Trial rules:
  - Non-hit trial commits on the next edge.
  - Hit on a move or rotate: discard the trial; state unchanged.
  - Hit on a down trial: -> LOCK.
  - A command pulse that coincides with a higher-priority trial is dropped, not queued.
- Hard drop: cmd_drop latches a drop flag and ignores further commands until lock.
- x arithmetic wraps in 4 bits. The external checker must report hit for out-of-range x. y=0 with down trial must be reported as hit by the checker.
- State LOCK:
  - lock_req=1; pos/float held stable.
  - game_over sampled on the LOCK entry cycle into a flag.
  - On lock_ack: lock_req=0, piece_valid=0; flag=1 -> OVER, else -> SPAWN.
  - lock_ack outside LOCK is ignored.
- State OVER: over=1, piece_valid=0. start -> SPAWN with over cleared.
- piece_valid=1 exactly in FALL and LOCK.
- Reset asserted mid-operation: immediate return to reset values. No lock_req is left pending.

Optional Feature:
- NEXT_PIECE_EN defined:
  - Adds output next_kind[2:0].
  - SPAWN uses the registered next_kind and loads next_kind from the LFSR in the same cycle.
  - next_kind is loaded from the LFSR on the start pulse.
  - Reset value 0.
- Undefined: no port; SPAWN takes kind directly from the LFSR.

Decomposition:
- Shared package tetris_pkg:
  - Piece-kind constants KIND_I..KIND_L.
  - 7x4 table of 16-bit shape masks SHAPE[kind][rot], [0:15] bit order matching float.
  - FSM state encoding.
  - Board width/height constants (10, 24).
- Sub-module piece_lfsr holds the generator and kind mapping. Everything else stays in one module.

Test Plan:
- Reset, start with collision checker stubbed to hit=0 except y==0 or x>6 -> SPAWN then FALL; pos=(3,20); float=SHAPE[kind][0]; piece_valid=1.
- GRAVITY_CYCLES=4, no commands -> pos_y decrements every 4 cycles, 20->0. Next down trial hits -> lock_req=1 with pos_y=0. lock_ack -> new SPAWN.
- cmd_left x4 from x=3 -> x=0, then fourth pulse (x wraps to 15) rejected by hit, x stays 0. cmd_rot x4 -> rot cycles 0,1,2,3,0 and float tracks the table.
- cmd_left coincident with gravity-due cycle -> only y decrements; x unchanged.
- cmd_drop at y=20 (DROP_CYCLES=1) -> y reaches 0 in 20 cycles; cmd_rot during drop ignored; then LOCK.
- game_over=1 forced at lock -> after lock_ack: over=1, piece_valid=0. start -> SPAWN, over=0. Spawn with hit=1 -> OVER directly with no lock_req.
